clk_enable_divider: RTL and testbench



---
 rtl/clk_enable_divider.sv | 126 ++++++++++++
 tb/tb_clk_enable_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clk_enable_divider.sv
// clk_enable_divider
// Multi-channel clock-enable generator for the 50 MHz system clock domain.
// Each channel divides the system clock by a run-time divisor and produces
// a one-cycle enable strobe (o_ce) and a registered square wave (o_clk_sq)
// with the same period. o_lock reports that the divisors are latched and the
// channel outputs have been running undisturbed for LOCK_CYCLES cycles.
//
// Channel rule, with E = max(D, 1):
//   cnt      <= (cnt == E-1) ? 0 : cnt + 1
//   o_ce     <= (cnt == E-1)
//   o_clk_sq <= (cnt < E/2)
// Reset and i_div_load both latch i_div and clear every counter and output.
// If both are asserted together, reset wins, which gives the same result.
// o_ce / o_clk_sq are deliberately not gated by o_lock; consumers qualify
// them with o_lock themselves.
module clk_enable_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEBUG       = 0
) (
  input  logic                    i_clk50,
  input  logic                    i_reset,
  input  logic [NUM_CH*CNT_W-1:0] i_div,
  input  logic                    i_div_load,
  output logic [NUM_CH-1:0]       o_ce,
  output logic [NUM_CH-1:0]       o_clk_sq,
  output logic                    o_lock
);

  // Lock counter is wide enough to hold LOCK_CYCLES; the DEBUG build only
  // needs to count to 1, which always fits.
  localparam int LK_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0] LOCK_TH = (DEBUG != 0) ? LK_W'(1) : LK_W'(LOCK_CYCLES);

  // Per-channel state
  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            ce_q, ce_d;
  logic [NUM_CH-1:0]            sq_q, sq_d;

  // Per-channel decoded terms of the latched divisor
  logic [NUM_CH-1:0][CNT_W-1:0] eff_w;
  logic [NUM_CH-1:0][CNT_W-1:0] last_w;
  logic [NUM_CH-1:0][CNT_W-1:0] half_w;

  // Lock tracking
  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            lock_q, lock_d;

  // Reset or load: both restart every channel from a clean period.
  logic clear;
  assign clear = i_reset | i_div_load;

  // Effective divisor (0 behaves as 1), terminal count and high-phase length.
  always_comb begin
    eff_w  = '0;
    last_w = '0;
    half_w = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      eff_w[n]  = (div_q[n] == '0) ? CNT_W'(1) : div_q[n];
      last_w[n] = eff_w[n] - CNT_W'(1);
      half_w[n] = eff_w[n] >> 1;
    end
  end

  // Channel next state: wrap at E-1, strobe on the terminal count, high
  // phase while the count is below E/2. A load aborts the current period.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    ce_d  = '0;
    sq_d  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (clear) begin
        div_d[n] = i_div[n*CNT_W +: CNT_W];
        cnt_d[n] = '0;
        ce_d[n]  = 1'b0;
        sq_d[n]  = 1'b0;
      end else begin
        cnt_d[n] = (cnt_q[n] == last_w[n]) ? '0 : cnt_q[n] + CNT_W'(1);
        ce_d[n]  = (cnt_q[n] == last_w[n]);
        sq_d[n]  = (cnt_q[n] < half_w[n]);
      end
    end
  end

  // Lock next state: count up to the threshold and hold; flag once reached.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_d     = 1'b0;
    if (clear) begin
      lock_cnt_d = '0;
      lock_d     = 1'b0;
    end else begin
      if (lock_cnt_q != LOCK_TH) begin
        lock_cnt_d = lock_cnt_q + LK_W'(1);
      end
      lock_d = (lock_cnt_q == LOCK_TH);
    end
  end

  // State registers; reset clears everything and captures the divisors.
  always_ff @(posedge i_clk50) begin
    if (i_reset) begin
      div_q      <= i_div;
      cnt_q      <= '0;
      ce_q       <= '0;
      sq_q       <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      sq_q       <= sq_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign o_ce     = ce_q;
  assign o_clk_sq = sq_q;
  assign o_lock   = lock_q;

endmodule

// File: tb/tb_clk_enable_divider.sv
// Testbench for clk_enable_divider.
// Three builds share one reset/load stimulus: a default 2-channel build, the
// same build with DEBUG=1, and a 1-channel CNT_W=4 build for the
// maximum-divisor case. The reference model counts edges k since the last
// reset/load release and derives every output arithmetically from k:
//   o_ce     = k>=1 && k % E == 0
//   o_clk_sq = k>=1 && (k-1) % E < E/2
//   o_lock   = k >= threshold + 1
module tb_clk_enable_divider;

  // Clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst  = 1'b1;
  logic        load = 1'b0;
  logic [31:0] div_a = {16'd5, 16'd2};
  logic [3:0]  div_c = 4'd15;

  logic [1:0] ce_a, sq_a, ce_b, sq_b;
  logic       lock_a, lock_b;
  logic [0:0] ce_c, sq_c;
  logic       lock_c;

  clk_enable_divider #(.NUM_CH(2), .CNT_W(16), .LOCK_CYCLES(16), .DEBUG(0)) dut_a (
    .i_clk50(clk), .i_reset(rst), .i_div(div_a), .i_div_load(load),
    .o_ce(ce_a), .o_clk_sq(sq_a), .o_lock(lock_a));

  clk_enable_divider #(.NUM_CH(2), .CNT_W(16), .LOCK_CYCLES(16), .DEBUG(1)) dut_b (
    .i_clk50(clk), .i_reset(rst), .i_div(div_a), .i_div_load(load),
    .o_ce(ce_b), .o_clk_sq(sq_b), .o_lock(lock_b));

  clk_enable_divider #(.NUM_CH(1), .CNT_W(4), .LOCK_CYCLES(3), .DEBUG(0)) dut_c (
    .i_clk50(clk), .i_reset(rst), .i_div(div_c), .i_div_load(load),
    .o_ce(ce_c), .o_clk_sq(sq_c), .o_lock(lock_c));

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int k   = 0;
  int ea0 = 1;
  int ea1 = 1;
  int ec  = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic m_ce(input int e, input int kk);
    return (kk >= 1) && (kk % e == 0);
  endfunction

  function automatic logic m_sq(input int e, input int kk);
    return (kk >= 1) && (((kk - 1) % e) < (e / 2));
  endfunction

  // One clock: update the model from the inputs present at the edge, then
  // compare every output of every build shortly after the edge.
  task automatic step();
    @(posedge clk);
    if (rst || load) begin
      k   = 0;
      ea0 = eff(int'(div_a[15:0]));
      ea1 = eff(int'(div_a[31:16]));
      ec  = eff(int'(div_c));
    end else begin
      k++;
    end
    #1;
    chk("a_ce",   32'(ce_a),   32'({m_ce(ea1, k), m_ce(ea0, k)}));
    chk("a_sq",   32'(sq_a),   32'({m_sq(ea1, k), m_sq(ea0, k)}));
    chk("a_lock", 32'(lock_a), 32'(k >= 17));
    chk("b_ce",   32'(ce_b),   32'({m_ce(ea1, k), m_ce(ea0, k)}));
    chk("b_sq",   32'(sq_b),   32'({m_sq(ea1, k), m_sq(ea0, k)}));
    chk("b_lock", 32'(lock_b), 32'(k >= 2));
    chk("c_ce",   32'(ce_c),   32'(m_ce(ec, k)));
    chk("c_sq",   32'(sq_c),   32'(m_sq(ec, k)));
    chk("c_lock", 32'(lock_c), 32'(k >= 4));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [31:0] da, input logic [3:0] dc);
    div_a = da;
    div_c = dc;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    // Reset state with ch0=2, ch1=5, then free run past lock.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(40);

    // Divisor 0 then 1 on ch0 (both behave as E=1).
    pulse_load({16'd5, 16'd0}, 4'd0);
    run(20);
    pulse_load({16'd5, 16'd1}, 4'd1);
    run(20);

    // Divisor change without a load has no effect.
    div_a = {16'd7, 16'd9};
    div_c = 4'd2;
    run(15);

    // Load mid-period: ch1=5 running, reload with ch1=3 when its count is 2.
    pulse_load({16'd5, 16'd2}, 4'd15);
    for (int i = 0; i < 10 && (k % 5) != 2; i++) step();
    chk("midload_align", 32'(k % 5), 32'd2);
    pulse_load({16'd3, 16'd2}, 4'd15);
    run(25);

    // Reset and load together mid-operation.
    run(7);
    div_a = {16'd4, 16'd6};
    div_c = 4'd11;
    rst   = 1'b1;
    load  = 1'b1;
    step();
    rst   = 1'b0;
    load  = 1'b0;
    run(30);

    // Maximum divisor on the 4-bit build, several full periods.
    pulse_load({16'd15, 16'd15}, 4'd15);
    run(70);

    // Randomised: loads, resets, combined pulses and unloaded divisor churn.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      rst  = (r < 5);
      load = (r >= 5 && r < 25) || (r < 2);
      if ($urandom_range(0, 9) == 0) begin
        div_a[15:0]  = 16'($urandom_range(0, 12));
        div_a[31:16] = 16'($urandom_range(0, 12));
        div_c        = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      end
      step();
    end
    rst  = 1'b0;
    load = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
